// File: rtl/rate_det_pkg.sv
// Shared definitions for the rate detector.
//   state_t       FSM state encoding (IDLE, MEASURE, LOCKED)
//   RATE_*        2-bit rate codes, 00 = slowest (N_0) .. 11 = fastest (N_3)
//   nominal()     nominal half-period N_k = 2^(base_log2+3-k) in clock cycles
//   tolerance()   allowed deviation N_k/8
//   lowBound()    smallest half-period accepted for class k
//   highBound()   largest half-period accepted for class k
package rate_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [1:0] RATE_N0 = 2'b00;
  localparam logic [1:0] RATE_N1 = 2'b01;
  localparam logic [1:0] RATE_N2 = 2'b10;
  localparam logic [1:0] RATE_N3 = 2'b11;

  function automatic int nominal(input int base_log2, input int k);
    return 1 << (base_log2 + 3 - k);
  endfunction

  function automatic int tolerance(input int base_log2, input int k);
    return nominal(base_log2, k) >> 3;
  endfunction

  function automatic int lowBound(input int base_log2, input int k);
    return nominal(base_log2, k) - tolerance(base_log2, k);
  endfunction

  function automatic int highBound(input int base_log2, input int k);
    return nominal(base_log2, k) + tolerance(base_log2, k);
  endfunction

endpackage

// File: rtl/rate_detector_sync_edge.sv
// sync_edge: brings the slow asynchronous square wave into the clock domain
// and flags every transition of either polarity.
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset, clears all flops to 0
//   i_async  asynchronous input level
//   o_edge   high for one cycle after the synchronized level changes
module sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_edge
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Two-flop synchronizer followed by one more flop holding the previous
  // synchronized level, so the edge flag never looks at a metastable value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_edge = r_sync ^ r_prev;

endmodule

// File: rtl/rate_detector.sv
// rate_detector: measures the half-period of a slow square wave and locks
// onto one of four nominal speed classes once two consecutive half-periods
// agree.
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_in_clk      slow square wave, asynchronous to i_clk
//   o_rate        recovered speed class, 00 slowest .. 11 fastest
//   o_rate_valid  high while locked
//   o_err         one-cycle pulse on a rejected measurement, unlock or timeout
module rate_detector
  import rate_det_pkg::*;
#(
  parameter int BASE_LOG2 = 22
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_in_clk,
  output logic [1:0] o_rate,
  output logic       o_rate_valid,
  output logic       o_err
);

  localparam int W = BASE_LOG2 + 5;
  localparam logic [W-1:0] TMO = W'(2 * nominal(BASE_LOG2, 0));

  logic         w_edge;
  logic [W-1:0] w_measured;
  logic         w_timeout;
  logic [3:0]   w_match;
  logic         w_class_valid;
  logic [1:0]   w_class;

  logic [W-1:0] r_run_cnt;
  state_t       r_state;
  logic [1:0]   r_rate;
  logic         r_rate_valid;
  logic         r_err;
  logic [1:0]   r_cand;
  logic         r_cand_valid;

  state_t       w_state_nxt;
  logic [1:0]   w_rate_nxt;
  logic         w_rate_valid_nxt;
  logic         w_err_nxt;
  logic [1:0]   w_cand_nxt;
  logic         w_cand_valid_nxt;

  sync_edge u_sync_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_in_clk),
    .o_edge  (w_edge)
  );

  // Cycles since the last edge; saturates so a dead input cannot wrap
  // around into a plausible-looking measurement.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run_cnt <= '0;
    end else if (w_edge) begin
      r_run_cnt <= '0;
    end else if (r_run_cnt != TMO) begin
      r_run_cnt <= r_run_cnt + W'(1);
    end
  end

  // The edge cycle itself counts, hence the +1.
  assign w_measured = r_run_cnt + W'(1);
  assign w_timeout  = (r_run_cnt == TMO);

  // Tolerance windows are disjoint, so at most one bit of w_match is set.
  for (genvar k = 0; k < 4; k++) begin : g_class
    localparam logic [W-1:0] LO = W'(lowBound(BASE_LOG2, k));
    localparam logic [W-1:0] HI = W'(highBound(BASE_LOG2, k));
    assign w_match[k] = (w_measured >= LO) && (w_measured <= HI);
  end

  always_comb begin
    w_class_valid = |w_match;
    w_class       = RATE_N0;
    if (w_match[1]) w_class = RATE_N1;
    if (w_match[2]) w_class = RATE_N2;
    if (w_match[3]) w_class = RATE_N3;
  end

  // Lock state machine; an edge takes precedence over a coincident timeout.
  always_comb begin
    w_state_nxt      = r_state;
    w_rate_nxt       = r_rate;
    w_rate_valid_nxt = r_rate_valid;
    w_err_nxt        = 1'b0;
    w_cand_nxt       = r_cand;
    w_cand_valid_nxt = r_cand_valid;
    case (r_state)
      ST_IDLE: begin
        if (w_edge) begin
          w_state_nxt      = ST_MEASURE;
          w_cand_valid_nxt = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (w_edge) begin
          if (w_class_valid) begin
            if (r_cand_valid && (r_cand == w_class)) begin
              w_state_nxt      = ST_LOCKED;
              w_rate_nxt       = w_class;
              w_rate_valid_nxt = 1'b1;
            end else begin
              w_cand_nxt       = w_class;
              w_cand_valid_nxt = 1'b1;
            end
          end else begin
            w_err_nxt        = 1'b1;
            w_cand_valid_nxt = 1'b0;
          end
        end else if (w_timeout) begin
          w_state_nxt      = ST_IDLE;
          w_rate_valid_nxt = 1'b0;
          w_err_nxt        = 1'b1;
          w_cand_valid_nxt = 1'b0;
        end
      end
      ST_LOCKED: begin
        if (w_edge) begin
          if (!(w_class_valid && (w_class == r_rate))) begin
            w_state_nxt      = ST_MEASURE;
            w_rate_valid_nxt = 1'b0;
            w_err_nxt        = 1'b1;
            w_cand_nxt       = w_class;
            w_cand_valid_nxt = w_class_valid;
          end
        end else if (w_timeout) begin
          w_state_nxt      = ST_IDLE;
          w_rate_valid_nxt = 1'b0;
          w_err_nxt        = 1'b1;
          w_cand_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt      = ST_IDLE;
        w_rate_valid_nxt = 1'b0;
        w_cand_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_rate       <= RATE_N0;
      r_rate_valid <= 1'b0;
      r_err        <= 1'b0;
      r_cand       <= RATE_N0;
      r_cand_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rate       <= w_rate_nxt;
      r_rate_valid <= w_rate_valid_nxt;
      r_err        <= w_err_nxt;
      r_cand       <= w_cand_nxt;
      r_cand_valid <= w_cand_valid_nxt;
    end
  end

  assign o_rate       = r_rate;
  assign o_rate_valid = r_rate_valid;
  assign o_err        = r_err;

endmodule

// File: tb/tb_rate_detector.sv
// Directed bench for rate_detector with BASE_LOG2=2
// (N_3=4, N_2=8, N_1=16, N_0=32, timeout 64).
module tb_rate_detector;

  logic       clock;
  logic       rstN;
  logic       inClk;
  logic [1:0] rate;
  logic       rateValid;
  logic       err;

  int compared   = 0;
  int mismatched = 0;
  int errPulses  = 0;
  int snap       = 0;

  rate_detector #(.BASE_LOG2(2)) dut (
    .i_clk        (clock),
    .i_rst_n      (rstN),
    .i_in_clk     (inClk),
    .o_rate       (rate),
    .o_rate_valid (rateValid),
    .o_err        (err)
  );

  // Free-running system clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every cycle with err high is one pulse-cycle; used to count pulses.
  always @(negedge clock) begin
    if (err === 1'b1) errPulses++;
  end

  task automatic checkValue(input string tag, input int actual, input int expected);
    compared++;
    assert (actual === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] expRate,
                             input logic expValid, input logic expErr);
    compared++;
    assert (rate === expRate) else begin
      mismatched++;
      $error("[TB] FAIL %s.rate: observed %b expected %b", tag, rate, expRate);
    end
    compared++;
    assert (rateValid === expValid) else begin
      mismatched++;
      $error("[TB] FAIL %s.rate_valid: observed %b expected %b", tag, rateValid, expValid);
    end
    compared++;
    assert (err === expErr) else begin
      mismatched++;
      $error("[TB] FAIL %s.err: observed %b expected %b", tag, err, expErr);
    end
  endtask

  // Toggle the slow input at a falling clock edge, then wait until the
  // registered outputs for that transition are visible (three rising edges).
  task automatic applyStimulus();
    inClk = ~inClk;
    repeat (3) @(negedge clock);
  endtask

  // One transition, check the outputs it produced, then hold the level so
  // the next transition lands exactly 'hold' cycles later.
  task automatic edgeAndCheck(input int hold, input logic [1:0] expRate,
                              input logic expValid, input logic expErr,
                              input string tag);
    applyStimulus();
    checkOutput(tag, expRate, expValid, expErr);
    repeat (hold - 3) @(negedge clock);
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic applyReset(input string tag);
    #2;
    rstN  = 1'b0;
    inClk = 1'b0;
    #1;
    checkOutput(tag, 2'b00, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    rstN = 1'b1;
  endtask

  initial begin
    inClk = 1'b0;
    rstN  = 1'b1;
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("reset", 2'b00, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    rstN = 1'b1;

    // Half-period 8 locks on the third edge to rate 10.
    snap = errPulses;
    edgeAndCheck(8, 2'b00, 1'b0, 1'b0, "p8_e1");
    edgeAndCheck(8, 2'b00, 1'b0, 1'b0, "p8_e2");
    edgeAndCheck(8, 2'b10, 1'b1, 1'b0, "p8_lock");
    edgeAndCheck(8, 2'b10, 1'b1, 1'b0, "p8_hold");
    checkValue("p8_no_err", errPulses - snap, 0);

    applyReset("rst_locked10");

    // Half-period 12 is unclassified: err on every edge after the first.
    edgeAndCheck(12, 2'b00, 1'b0, 1'b0, "p12_e1");
    edgeAndCheck(12, 2'b00, 1'b0, 1'b1, "p12_e2");
    edgeAndCheck(12, 2'b00, 1'b0, 1'b1, "p12_e3");
    edgeAndCheck(32, 2'b00, 1'b0, 1'b1, "p12_e4");

    // Lock at 32, then switch to 16.
    edgeAndCheck(32, 2'b00, 1'b0, 1'b0, "p32_cand");
    edgeAndCheck(32, 2'b00, 1'b1, 1'b0, "p32_lock");
    edgeAndCheck(16, 2'b00, 1'b1, 1'b0, "p32_hold");
    edgeAndCheck(16, 2'b00, 1'b0, 1'b1, "p16_unlock");
    edgeAndCheck(32, 2'b01, 1'b1, 1'b0, "p16_lock");

    // Back to 32 (candidate taken from the unlocking edge), then stall.
    edgeAndCheck(32, 2'b01, 1'b0, 1'b1, "p32_unlock");
    snap = errPulses;
    edgeAndCheck(80, 2'b00, 1'b1, 1'b0, "p32_relock");
    checkValue("tmo_one_err", errPulses - snap, 1);
    checkOutput("tmo_state", 2'b00, 1'b0, 1'b0);

    // After timeout the FSM is idle: a huge measurement raises no err.
    edgeAndCheck(36, 2'b00, 1'b0, 1'b0, "idle_after_tmo");

    // N_0 tolerance window edges: 36 and 28 accepted, 37 and 27 rejected.
    edgeAndCheck(36, 2'b00, 1'b0, 1'b0, "p36_cand");
    edgeAndCheck(28, 2'b00, 1'b1, 1'b0, "p36_lock");
    edgeAndCheck(28, 2'b00, 1'b1, 1'b0, "p28_hold");
    edgeAndCheck(37, 2'b00, 1'b1, 1'b0, "p28_hold2");
    edgeAndCheck(27, 2'b00, 1'b0, 1'b1, "p37_err");
    edgeAndCheck(28, 2'b00, 1'b0, 1'b1, "p27_err");
    edgeAndCheck(36, 2'b00, 1'b0, 1'b0, "p28_cand");
    edgeAndCheck(8,  2'b00, 1'b1, 1'b0, "p36_lock2");

    // Move to rate 10 so the reset below has something to clear.
    edgeAndCheck(8, 2'b00, 1'b0, 1'b1, "p8_unlock");
    edgeAndCheck(8, 2'b10, 1'b1, 1'b0, "p8_relock");

    applyReset("rst_locked10b");

    // Fresh relock needs three edges; half-period 4 is the fastest class.
    edgeAndCheck(4, 2'b00, 1'b0, 1'b0, "p4_e1");
    edgeAndCheck(4, 2'b00, 1'b0, 1'b0, "p4_e2");
    edgeAndCheck(4, 2'b11, 1'b1, 1'b0, "p4_lock");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
